branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequences control-flow redirects for the in-order RISC-V core pipeline. It resolves the conditional branch or jump in EX and produces a registered PC redirect to the instruction-fetch/I-cache port. It flushes the younger pipeline stages and holds the redirect until the I-cache accepts it, so cache-miss back-pressure from the multicore cache controller never drops a redirect. It sits between the EX stage and the fetch unit of each core.

## Interface
- XLEN, 32, datapath and PC width
- clk  in  1  core clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX holds a live instruction this cycle
- ex_opcode  in  7  opcode of EX instruction
- ex_funct3  in  3  funct3 of EX instruction (branch type)
- ex_rs1, ex_rs2  in  XLEN  operands for comparison
- ex_target  in  XLEN  target computed by EX (PC+imm or rs1+imm)
- imem_ready  in  1  fetch/I-cache accepts a redirect address this cycle
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  XLEN  redirect address, stable while redirect_valid
- flush  out  1  kill IF/ID and ID/EX contents this cycle
- br_taken  out  1  one-cycle pulse: a redirect was just issued

## Operation
- Taken decode:
  - JAL (1101111) is always taken.
  - JALR (1100111) is always taken; the target has bit 0 cleared.
  - BRANCH (1100011) uses funct3:
    - 000 BEQ and 001 BNE.
    - 100 BLT and 101 BGE, signed.
    - 110 BLTU and 111 BGEU, unsigned.
    - 010 and 011 are not taken.
  - All other opcodes are not taken.
- FSM states are IDLE and PENDING.
- IDLE:
  - If ex_valid and taken, latch the target into redirect_pc and raise redirect_valid, flush and br_taken on the next cycle.
  - If imem_ready is high in that next cycle, return to IDLE; otherwise go to PENDING.
- PENDING:
  - Hold redirect_valid=1, flush=1 and redirect_pc unchanged.
  - br_taken=0.
  - Leave for IDLE in the cycle after redirect_valid & imem_ready.
- While redirect_valid=1, ex_valid is ignored. The stage is being flushed, so no new resolution is accepted.
- A redirect is consumed exactly once, on the redirect_valid & imem_ready cycle.

## Timing
- Reset values are redirect_valid=0, redirect_pc=0, flush=0, br_taken=0, state=IDLE.
- Latency is 1 cycle: a resolution in cycle N gives redirect_valid/flush/br_taken in cycle N+1.
- Back-to-back operation: if the redirect is accepted in cycle N+1 and a taken branch is in EX in cycle N+2, a new redirect appears in cycle N+3.
- Reset asserted in PENDING abandons the redirect; all outputs are 0 in the next cycle.
- imem_ready while redirect_valid=0 has no effect.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro BRANCH_REDIRECT_STATS_EN.
- Defined:
  - Adds 32-bit outputs stat_branches (resolved BRANCH ops), stat_taken (issued redirects) and stat_stall_cycles (cycles in PENDING).
  - All three counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the counters and ports are absent and behaviour is otherwise identical.

## Structure
- Package branch_pkg holds:
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - An enum for funct3 branch types.
  - The FSM state enum.
- Sub-module branch_cond_eval is purely combinational: opcode, funct3, rs1, rs2 in; taken out. The controller instantiates it once.

## Test plan
- BEQ: rs1=5, rs2=5, target=0x100, imem_ready=1 → redirect_valid=1, redirect_pc=0x100, flush=1, br_taken=1 for exactly one cycle.
- BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1 → BLT taken, BLTU not taken (no redirect); BGEU with the same operands is taken.
- JALR with target=0x203 → redirect_pc=0x202.
- imem_ready=0 for 3 cycles after the taken branch:
  - redirect_valid/flush stay high for 4 cycles and redirect_pc is stable.
  - br_taken pulses only in the first cycle.
  - A taken ex_valid during the stall is ignored.
- Reset asserted during PENDING → all outputs 0 in the next cycle; no redirect when imem_ready later rises.
- With BRANCH_REDIRECT_STATS_EN: 3 branches (2 taken, one stalled 2 cycles) → stat_branches=3, stat_taken=2, stat_stall_cycles=2.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants and types for the branch redirect controller.
package branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3Beq  = 3'b000,
    F3Bne  = 3'b001,
    F3Blt  = 3'b100,
    F3Bge  = 3'b101,
    F3Bltu = 3'b110,
    F3Bgeu = 3'b111
  } br_funct3_e;

  typedef enum logic {
    StIdle,
    StPending
  } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational taken/not-taken decision for JAL, JALR and conditional branches.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_JAL, OP_JALR: taken = 1'b1;
      OP_BRANCH: begin
        case (br_funct3_e'(funct3))
          F3Beq:   taken = (rs1 == rs2);
          F3Bne:   taken = (rs1 != rs2);
          F3Blt:   taken = ($signed(rs1) <  $signed(rs2));
          F3Bge:   taken = ($signed(rs1) >= $signed(rs2));
          F3Bltu:  taken = (rs1 <  rs2);
          F3Bgeu:  taken = (rs1 >= rs2);
          default: taken = 1'b0;
        endcase
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves EX control flow and holds a registered PC redirect until fetch accepts it.
// Optional counters are enabled with the BRANCH_REDIRECT_STATS_EN macro.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_target,
  input  logic            imem_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            br_taken
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_stall_cycles
`endif
);

  br_state_e       state;
  logic            ex_taken;
  logic [XLEN-1:0] target_pc;

  branch_cond_eval #(
    .XLEN (XLEN)
  ) u_cond (
    .opcode (ex_opcode),
    .funct3 (ex_funct3),
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .taken  (ex_taken)
  );

  assign target_pc = (ex_opcode == OP_JALR) ? {ex_target[XLEN-1:1], 1'b0} : ex_target;

  // StIdle with redirect_valid set is the issue cycle; only later cycles count as PENDING.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= StIdle;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      br_taken       <= 1'b0;
    end else begin
      br_taken <= 1'b0;
      unique case (state)
        StIdle: begin
          if (redirect_valid) begin
            if (imem_ready) begin
              redirect_valid <= 1'b0;
              flush          <= 1'b0;
            end else begin
              state <= StPending;
            end
          end else if (ex_valid && ex_taken) begin
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
            br_taken       <= 1'b1;
            redirect_pc    <= target_pc;
          end
        end
        StPending: begin
          if (imem_ready) begin
            state          <= StIdle;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef BRANCH_REDIRECT_STATS_EN
  logic resolve;
  assign resolve = ex_valid && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches     <= '0;
      stat_taken        <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (resolve && (ex_opcode == OP_BRANCH) && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (resolve && ex_taken && (stat_taken != 32'hFFFF_FFFF)) begin
        stat_taken <= stat_taken + 32'd1;
      end
      if ((state == StPending) && (stat_stall_cycles != 32'hFFFF_FFFF)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench: vector table, directed multi-cycle sequences, random vs reference model.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2, ex_target;
  logic        imem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        br_taken;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_stall_cycles;
`endif

  branch_redirect_ctrl #(
    .XLEN (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_funct3      (ex_funct3),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_target      (ex_target),
    .imem_ready     (imem_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .br_taken       (br_taken)
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    .stat_branches     (stat_branches),
    .stat_taken        (stat_taken),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: at most one outstanding redirect, plus event counters.
  logic [31:0] m_q[$];
  bit          m_fresh;
  logic [31:0] m_br, m_tk, m_st;

  function automatic bit ref_taken(logic [6:0] op, logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    if (op == 7'h6f || op == 7'h67) return 1'b1;
    if (op != 7'h63) return 1'b0;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_q.delete();
      m_fresh = 1'b0;
      m_br = '0; m_tk = '0; m_st = '0;
    end else if (m_q.size() != 0) begin
      if (!m_fresh) m_st++;
      if (imem_ready) m_q.delete();
      m_fresh = 1'b0;
    end else begin
      m_fresh = 1'b0;
      if (ex_valid) begin
        if (ex_opcode == 7'h63) m_br++;
        if (ref_taken(ex_opcode, ex_funct3, ex_rs1, ex_rs2)) begin
          m_q.push_back(ex_opcode == 7'h67 ? (ex_target & ~32'd1) : ex_target);
          m_fresh = 1'b1;
          m_tk++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("model_valid", {31'd0, redirect_valid}, {31'd0, m_q.size() != 0});
    chk("model_flush", {31'd0, flush}, {31'd0, m_q.size() != 0});
    chk("model_br_taken", {31'd0, br_taken}, {31'd0, m_fresh});
    if (m_q.size() != 0) chk("model_pc", redirect_pc, m_q[0]);
`ifdef BRANCH_REDIRECT_STATS_EN
    chk("model_stat_branches", stat_branches, m_br);
    chk("model_stat_taken", stat_taken, m_tk);
    chk("model_stat_stall", stat_stall_cycles, m_st);
`endif
  endtask

  task automatic drive(logic v, logic [6:0] op, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                       logic [31:0] t, logic rdy);
    ex_valid = v; ex_opcode = op; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_target = t; imem_ready = rdy;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] tgt;
    logic        tk;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{7'h63, 3'd0, 32'd5,        32'd5, 32'h100,  1'b1, 32'h100};
    tbl[1]  = '{7'h63, 3'd1, 32'd5,        32'd5, 32'h104,  1'b0, 32'h0};
    tbl[2]  = '{7'h63, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h200,  1'b1, 32'h200};
    tbl[3]  = '{7'h63, 3'd6, 32'hFFFFFFFF, 32'd1, 32'h204,  1'b0, 32'h0};
    tbl[4]  = '{7'h63, 3'd7, 32'hFFFFFFFF, 32'd1, 32'h300,  1'b1, 32'h300};
    tbl[5]  = '{7'h63, 3'd5, 32'hFFFFFFFF, 32'd1, 32'h304,  1'b0, 32'h0};
    tbl[6]  = '{7'h63, 3'd2, 32'd7,        32'd7, 32'h308,  1'b0, 32'h0};
    tbl[7]  = '{7'h6f, 3'd0, 32'd0,        32'd0, 32'h1235, 1'b1, 32'h1235};
    tbl[8]  = '{7'h67, 3'd0, 32'd0,        32'd0, 32'h203,  1'b1, 32'h202};
    tbl[9]  = '{7'h33, 3'd0, 32'd1,        32'd1, 32'h400,  1'b0, 32'h0};
    tbl[10] = '{7'h63, 3'd1, 32'd1,        32'd2, 32'h44,   1'b1, 32'h44};

    reset = 1'b1;
    drive(1'b0, 7'h0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk("reset_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset_pc", redirect_pc, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_br_taken", {31'd0, br_taken}, 32'd0);
    reset = 1'b0;
    step();

    // Table vectors: one resolution, then an idle cycle to drain.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].tgt, 1'b1);
      step();
      chk($sformatf("tbl%0d_valid", i), {31'd0, redirect_valid}, {31'd0, tbl[i].tk});
      chk($sformatf("tbl%0d_br_taken", i), {31'd0, br_taken}, {31'd0, tbl[i].tk});
      if (tbl[i].tk) chk($sformatf("tbl%0d_pc", i), redirect_pc, tbl[i].pc);
      ex_valid = 1'b0;
      step();
      chk($sformatf("tbl%0d_clear", i), {31'd0, redirect_valid}, 32'd0);
    end

    // Stall: ready low for 3 cycles, a taken branch offered mid-stall is ignored.
    drive(1'b1, 7'h63, 3'd0, 32'd3, 32'd3, 32'h500, 1'b0);
    step();
    chk("stall_c1_valid", {31'd0, redirect_valid}, 32'd1);
    chk("stall_c1_br_taken", {31'd0, br_taken}, 32'd1);
    drive(1'b1, 7'h6f, 3'd0, 32'd0, 32'd0, 32'h900, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      if (c == 4) imem_ready = 1'b0;
      step();
      chk($sformatf("stall_c%0d_valid", c), {31'd0, redirect_valid}, 32'd1);
      chk($sformatf("stall_c%0d_flush", c), {31'd0, flush}, 32'd1);
      chk($sformatf("stall_c%0d_br_taken", c), {31'd0, br_taken}, 32'd0);
      chk($sformatf("stall_c%0d_pc", c), redirect_pc, 32'h500);
    end
    drive(1'b0, 7'h0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
    chk("stall_done_valid", {31'd0, redirect_valid}, 32'd0);
    chk("stall_done_flush", {31'd0, flush}, 32'd0);

    // Back-to-back: accepted in N+1, new taken in N+2, redirect in N+3.
    drive(1'b1, 7'h6f, 3'd0, 32'd0, 32'd0, 32'h600, 1'b1);
    step();
    chk("b2b_first_pc", redirect_pc, 32'h600);
    ex_target = 32'h700;
    step();
    chk("b2b_gap_valid", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("b2b_second_valid", {31'd0, redirect_valid}, 32'd1);
    chk("b2b_second_pc", redirect_pc, 32'h700);
    chk("b2b_second_br_taken", {31'd0, br_taken}, 32'd1);
    drive(1'b0, 7'h0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();

    // Reset while PENDING abandons the redirect.
    drive(1'b1, 7'h63, 3'd0, 32'd9, 32'd9, 32'h800, 1'b0);
    step();
    ex_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rst_pend_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_pend_pc", redirect_pc, 32'd0);
    chk("rst_pend_flush", {31'd0, flush}, 32'd0);
    reset = 1'b0;
    imem_ready = 1'b1;
    step();
    chk("rst_pend_after_valid", {31'd0, redirect_valid}, 32'd0);
    step();
    chk("rst_pend_after2_valid", {31'd0, redirect_valid}, 32'd0);

`ifdef BRANCH_REDIRECT_STATS_EN
    // 3 branches, 2 taken, second taken one spends 2 cycles in PENDING.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 7'h63, 3'd0, 32'd1, 32'd1, 32'h40, 1'b1);
    step();
    ex_valid = 1'b0;
    step();
    drive(1'b1, 7'h63, 3'd1, 32'd5, 32'd5, 32'h44, 1'b1);
    step();
    drive(1'b1, 7'h63, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h48, 1'b0);
    step();
    ex_valid = 1'b0;
    step();
    step();
    imem_ready = 1'b1;
    step();
    step();
    chk("stats_branches", stat_branches, 32'd3);
    chk("stats_taken", stat_taken, 32'd2);
    chk("stats_stall", stat_stall_cycles, 32'd2);
`endif

    // Random traffic against the model.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 600; n++) begin
      int unsigned sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      a = $urandom();
      reset      = ($urandom_range(0, 49) == 0);
      ex_valid   = ($urandom_range(0, 3) != 0);
      ex_opcode  = (sel < 6) ? 7'h63 : (sel == 6) ? 7'h6f : (sel == 7) ? 7'h67 : 7'($urandom());
      ex_funct3  = 3'($urandom());
      ex_rs1     = a;
      ex_rs2     = ($urandom_range(0, 2) == 0) ? a : $urandom();
      ex_target  = $urandom();
      imem_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
